depth_tested_pixel_sink: RTL and testbench
==========================================

// Module: depth_tested_pixel_sink
// PURPOSE
//  Consumer end of the rasterizer pixel stream: accepts (hcount, vcount, z, color, last_pixel)
//  beats on a valid/ready handshake and depth-tests each against an internal z-buffer.
//  Pixels strictly closer than the stored depth update the z-buffer and emit a framebuffer write.
//  Sits between the graphics pipeline output and the framebuffer BRAM write port.
// PARAMETERS
//  FB_HRES      320  framebuffer width in pixels
//  FB_VRES      180  framebuffer height in pixels
//  Z_WIDTH      23   depth width (unsigned; smaller = closer)
//  COLOR_WIDTH  16   pixel color width
//  ADDR_WIDTH   $clog2(FB_HRES*FB_VRES)  derived localparam, not overridable
// PORTS
//  clk_in          in   1            system clock
//  rst_in          in   1            synchronous active-high reset
//  clear_in        in   1            request z-buffer clear (level sampled; acted on when drained)
//  valid_in        in   1            pixel beat valid
//  ready_out       out  1            sink can accept a beat this cycle
//  hcount_in       in   $clog2(FB_HRES)  pixel x
//  vcount_in       in   $clog2(FB_VRES)  pixel y
//  z_in            in   Z_WIDTH      pixel depth
//  color_in        in   COLOR_WIDTH  pixel color
//  last_pixel_in   in   1            final pixel of current triangle
//  fb_we_out       out  1            framebuffer write strobe
//  fb_addr_out     out  ADDR_WIDTH   framebuffer address = vcount*FB_HRES + hcount
//  fb_data_out     out  COLOR_WIDTH  framebuffer write data
//  tri_done_out    out  1            1-cycle pulse when the last_pixel beat retires
//  clearing_out    out  1            high while the z-buffer clear is in progress
// BEHAVIOUR
//  - Transfer occurs when valid_in && ready_out on a rising clk_in edge.
//  - FSM: CLEAR -> RUN -> DRAIN -> CLEAR.
//    CLEAR: writes all-ones depth to every z-buffer address, one per cycle, ascending from 0.
//      ready_out=0; clearing_out=1; goes to RUN after address FB_HRES*FB_VRES-1.
//    RUN: accepts beats. clear_in=1 -> DRAIN (ready_out drops in the same cycle).
//    DRAIN: ready_out=0 until the pipeline is empty, then CLEAR.
//  - Reset: FSM=CLEAR, clear address=0, pipeline valids=0.
//    fb_we_out=0, tri_done_out=0, clearing_out=1, ready_out=0, fb_addr_out=0, fb_data_out=0.
//  - rst_in mid-clear or mid-pipeline: in-flight pixels are discarded and the clear restarts at 0.
//  - Pipeline, fixed latency 3: beat accepted in cycle t issues a z-buffer read (2-cycle BRAM).
//    Compare happens in t+2; fb_we_out/fb_addr_out/fb_data_out are valid in t+3.
//    A passing depth writes z_in back to the z-buffer in t+3.
//  - Depth test: write iff z_in < stored (unsigned). Equal or greater is rejected: no fb write.
//  - Hazard: if the incoming address matches a valid address in stages t+1..t+3,
//    ready_out=0 until the match retires. No forwarding; gives read-after-write correctness.
//  - Out of range (hcount>=FB_HRES or vcount>=FB_VRES): beat is accepted and passes down the
//    pipeline, but performs no read, compare or write. Its last_pixel flag is still honoured.
//  - tri_done_out pulses in the cycle the last_pixel beat reaches stage t+3, pass or reject.
//  - clear_in asserted during CLEAR is ignored; it is not queued.
//  - ready_out is a registered function of FSM state OR the combinational hazard compare.
//    It does not depend on valid_in.
// CONFIGURATION
//  PIXEL_SINK_STATS_EN defined: adds outputs pass_count_out[31:0] and reject_count_out[31:0].
//    Each counts retired in-range pixels; both reset to 0 on rst_in and on entry to CLEAR.
//    Both saturate at all-ones.
//  Not defined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package gfx_pkg: typedef sink_state_t {CLEAR, RUN, DRAIN}; function pix_addr(h,v).
//    Z_CLEAR_VALUE constant = all-ones.
//  - Sub-module zbuf_ram: simple dual-port RAM (port A write, port B read, 2-cycle read latency),
//    depth FB_HRES*FB_VRES, width Z_WIDTH.
//  - Top level holds the FSM, the 3-stage pipeline, hazard compare and output registers.
// TESTING
//  1. Reset, then idle: clearing_out=1 for exactly FB_HRES*FB_VRES cycles, then ready_out=1,
//     no fb_we_out.
//  2. One beat (h=5,v=2,z=100,color=16'hF800) after the clear: fb_we_out=1 three cycles later,
//     fb_addr_out=645, fb_data_out=16'hF800.
//  3. Same pixel (5,2) sent z=200 then z=50, back to back: ready_out stalls on the 2nd beat.
//     z=200 is written; z=50 is then written too; exactly 2 writes.
//     Resend z=50: rejected (equal).
//  4. Beat with h=320 and last_pixel_in=1: no fb write; tri_done_out pulses 3 cycles after accept.
//  5. clear_in during a stream of 3 in-flight beats: all 3 retire, then clearing_out rises.
//     Pixel (5,2) with z=1000 is then accepted and written.
//  6. rst_in asserted during CLEAR at address 1000: clear restarts from 0; full-length
//     clearing_out window observed.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared types and helpers for the depth-tested pixel sink: FSM state encoding,
// z-buffer clear value and framebuffer address mapping.
package gfx_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DRAIN
  } sink_state_t;

  // Sliced down to the configured depth width by the user.
  localparam logic [63:0] Z_CLEAR_VALUE = '1;

  function automatic int unsigned pix_addr(input int unsigned h,
                                           input int unsigned v,
                                           input int unsigned hres);
    return v * hres + h;
  endfunction

endpackage

// File: rtl/depth_tested_pixel_sink_zbuf_ram.sv
// Simple dual-port z-buffer RAM: port A writes, port B reads with a
// two-cycle registered read latency.
module zbuf_ram #(
  parameter int unsigned DEPTH = 57600,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 23
) (
  input  logic          clk_in,
  input  logic          a_we_in,
  input  logic [AW-1:0] a_addr_in,
  input  logic [DW-1:0] a_data_in,
  input  logic          b_re_in,
  input  logic [AW-1:0] b_addr_in,
  output logic [DW-1:0] b_data_out
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;

  always_ff @(posedge clk_in) begin
    if (a_we_in) mem[a_addr_in] <= a_data_in;
    if (b_re_in) rd1_q <= mem[b_addr_in];
    rd2_q <= rd1_q;
  end

  assign b_data_out = rd2_q;

endmodule

// File: rtl/depth_tested_pixel_sink.sv
// Rasterizer pixel sink: depth-tests beats against an internal z-buffer and emits
// framebuffer writes. Define PIXEL_SINK_STATS_EN to add pass/reject counters.
module depth_tested_pixel_sink
  import gfx_pkg::*;
#(
  parameter int unsigned FB_HRES     = 320,
  parameter int unsigned FB_VRES     = 180,
  parameter int unsigned Z_WIDTH     = 23,
  parameter int unsigned COLOR_WIDTH = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(FB_HRES * FB_VRES),
  localparam int unsigned HW         = $clog2(FB_HRES),
  localparam int unsigned VW         = $clog2(FB_VRES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [HW-1:0]          hcount_in,
  input  logic [VW-1:0]          vcount_in,
  input  logic [Z_WIDTH-1:0]     z_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   last_pixel_in,
  output logic                   fb_we_out,
  output logic [ADDR_WIDTH-1:0]  fb_addr_out,
  output logic [COLOR_WIDTH-1:0] fb_data_out,
  output logic                   tri_done_out,
  output logic                   clearing_out
`ifdef PIXEL_SINK_STATS_EN
  ,
  output logic [31:0]            pass_count_out,
  output logic [31:0]            reject_count_out
`endif
);

  localparam int unsigned DEPTH = FB_HRES * FB_VRES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef struct packed {
    logic                   v;
    logic                   in_range;
    logic                   last;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [Z_WIDTH-1:0]     z;
    logic [COLOR_WIDTH-1:0] color;
  } stage_t;

  sink_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  stage_t                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic                  fb_we_q, fb_we_d;

  logic                  in_range, hazard, ready, accept;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [Z_WIDTH-1:0]    ram_wdata;
  logic [Z_WIDTH-1:0]    rd_data;

  always_comb begin
    in_range = (32'(hcount_in) < FB_HRES) && (32'(vcount_in) < FB_VRES);
    in_addr  = ADDR_WIDTH'(pix_addr(32'(hcount_in), 32'(vcount_in), FB_HRES));
    // No forwarding: stall until any in-flight write to this address has landed.
    hazard = in_range &&
             ((s1_q.v && s1_q.in_range && (s1_q.addr == in_addr)) ||
              (s2_q.v && s2_q.in_range && (s2_q.addr == in_addr)) ||
              (s3_q.v && s3_q.in_range && (s3_q.addr == in_addr)));
    ready  = (state_q == RUN) && !clear_in && !hazard;
    accept = valid_in && ready;

    state_d = state_q;
    clr_d   = '0;
    unique case (state_q)
      CLEAR: begin
        clr_d = clr_q + ADDR_WIDTH'(1);
        if (clr_q == LAST_ADDR) begin
          state_d = RUN;
          clr_d   = '0;
        end
      end
      RUN:     if (clear_in) state_d = DRAIN;
      DRAIN:   if (!s1_q.v && !s2_q.v && !s3_q.v) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase

    s1_d   = s1_q;
    s1_d.v = 1'b0;
    if (accept) begin
      s1_d = '{v: 1'b1, in_range: in_range, last: last_pixel_in,
               addr: in_addr, z: z_in, color: color_in};
    end
    s2_d   = s2_q;
    s2_d.v = 1'b0;
    if (s1_q.v) s2_d = s1_q;
    s3_d   = s3_q;
    s3_d.v = 1'b0;
    if (s2_q.v) s3_d = s2_q;

    fb_we_d = s2_q.v && s2_q.in_range && (s2_q.z < rd_data);

    ram_we    = (state_q == CLEAR) || fb_we_q;
    ram_waddr = (state_q == CLEAR) ? clr_q : s3_q.addr;
    ram_wdata = (state_q == CLEAR) ? Z_CLEAR_VALUE[Z_WIDTH-1:0] : s3_q.z;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      fb_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      fb_we_q <= fb_we_d;
    end
  end

  zbuf_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH),
    .DW    (Z_WIDTH)
  ) u_zbuf (
    .clk_in     (clk_in),
    .a_we_in    (ram_we),
    .a_addr_in  (ram_waddr),
    .a_data_in  (ram_wdata),
    .b_re_in    (accept && in_range),
    .b_addr_in  (in_addr),
    .b_data_out (rd_data)
  );

  assign ready_out    = ready;
  assign fb_we_out    = fb_we_q;
  assign fb_addr_out  = s3_q.addr;
  assign fb_data_out  = s3_q.color;
  assign tri_done_out = s3_q.v && s3_q.last;
  assign clearing_out = (state_q == CLEAR);

`ifdef PIXEL_SINK_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d, rej_cnt_q, rej_cnt_d;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    rej_cnt_d  = rej_cnt_q;
    if ((state_q != CLEAR) && (state_d == CLEAR)) begin
      pass_cnt_d = '0;
      rej_cnt_d  = '0;
    end else if (s3_q.v && s3_q.in_range) begin
      if (fb_we_q) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 32'd1;
      end else begin
        if (rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pass_cnt_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign pass_count_out   = pass_cnt_q;
  assign reject_count_out = rej_cnt_q;
`endif

endmodule

// File: tb/tb_depth_tested_pixel_sink.sv
// Directed bench for depth_tested_pixel_sink: vector table plus hand-written
// stall, drain/clear and reset sequences on a 320x4 framebuffer.
module tb_depth_tested_pixel_sink;

  localparam int DEPTH = 320 * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        ready_out;
  logic [8:0]  hcount = '0;
  logic [1:0]  vcount = '0;
  logic [22:0] z = '0;
  logic [15:0] color = '0;
  logic        last = 1'b0;
  logic        fb_we_out;
  logic [10:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        tri_done_out;
  logic        clearing_out;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          c;
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t wlog[$];

  typedef struct packed {
    logic [8:0]  h;
    logic [1:0]  v;
    logic [22:0] z;
    logic [15:0] color;
    logic        last;
    logic        exp_we;
    logic [10:0] exp_addr;
    logic        exp_tri;
  } vec_t;
  vec_t vecs[9];

  depth_tested_pixel_sink #(
    .FB_HRES     (320),
    .FB_VRES     (4),
    .Z_WIDTH     (23),
    .COLOR_WIDTH (16)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .clear_in      (clear),
    .valid_in      (valid),
    .ready_out     (ready_out),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .z_in          (z),
    .color_in      (color),
    .last_pixel_in (last),
    .fb_we_out     (fb_we_out),
    .fb_addr_out   (fb_addr_out),
    .fb_data_out   (fb_data_out),
    .tri_done_out  (tri_done_out),
    .clearing_out  (clearing_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we_out === 1'b1) wlog.push_back('{cyc, fb_addr_out, fb_data_out});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [8:0] h, input logic [1:0] v, input logic [22:0] zz,
                           input logic [15:0] c, input logic lst, output int acc);
    int tries = 0;
    hcount = h; vcount = v; z = zz; color = c; last = lst; valid = 1'b1;
    #1;
    while (ready_out !== 1'b1 && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (tries >= 50) chk("send_timeout", 32'(tries), 32'd0);
    acc = cyc;
    @(posedge clk); #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic check_at(input int c, input string nm, input logic we, input logic tr,
                          input logic [10:0] addr, input logic [15:0] data);
    int g = 0;
    while (cyc < c && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (cyc != c) chk({nm, "_cycle"}, 32'(cyc), 32'(c));
    @(negedge clk);
    chk({nm, "_we"}, 32'(fb_we_out), 32'(we));
    chk({nm, "_tri"}, 32'(tri_done_out), 32'(tr));
    if (we) begin
      chk({nm, "_addr"}, 32'(fb_addr_out), 32'(addr));
      chk({nm, "_data"}, 32'(fb_data_out), 32'(data));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Returns the length of the next clearing_out window and the cycle it started.
  task automatic measure_clear(output int n, output int rise);
    int g = 0;
    n = 0;
    @(negedge clk);
    while (clearing_out !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    rise = cyc;
    while (clearing_out === 1'b1 && n < 4 * DEPTH) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int acc, a1, a2, a3, n, rise, base;

    vecs[0] = '{9'd5,   2'd2, 23'd100,      16'hF800, 1'b0, 1'b1, 11'd645,  1'b0};
    vecs[1] = '{9'd10,  2'd0, 23'd5,        16'h1234, 1'b0, 1'b1, 11'd10,   1'b0};
    vecs[2] = '{9'd319, 2'd3, 23'h7FFFFE,   16'hABCD, 1'b0, 1'b1, 11'd1279, 1'b0};
    vecs[3] = '{9'd0,   2'd0, 23'h7FFFFF,   16'h0BAD, 1'b1, 1'b0, 11'd0,    1'b1};
    vecs[4] = '{9'd10,  2'd0, 23'd5,        16'h4321, 1'b0, 1'b0, 11'd10,   1'b0};
    vecs[5] = '{9'd10,  2'd0, 23'd6,        16'h4321, 1'b0, 1'b0, 11'd10,   1'b0};
    vecs[6] = '{9'd10,  2'd0, 23'd4,        16'h5555, 1'b1, 1'b1, 11'd10,   1'b1};
    vecs[7] = '{9'd0,   2'd1, 23'd0,        16'h0001, 1'b0, 1'b1, 11'd320,  1'b0};
    vecs[8] = '{9'd320, 2'd0, 23'd0,        16'hFFFF, 1'b0, 1'b0, 11'd0,    1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clearing", 32'(clearing_out), 32'd1);
    chk("rst_ready",    32'(ready_out),    32'd0);
    chk("rst_we",       32'(fb_we_out),    32'd0);
    chk("rst_tri",      32'(tri_done_out), 32'd0);
    chk("rst_addr",     32'(fb_addr_out),  32'd0);
    chk("rst_data",     32'(fb_data_out),  32'd0);

    // Test 1: full clear window after reset, then ready with no writes
    @(posedge clk); #1;
    rst = 1'b0;
    measure_clear(n, rise);
    chk("t1_clear_len", 32'(n), 32'(DEPTH));
    chk("t1_ready", 32'(ready_out), 32'd1);
    chk("t1_no_writes", 32'(wlog.size()), 32'd0);
    @(posedge clk); #1;

    // Test 2 and table: single beats with fixed 3-cycle latency
    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].h, vecs[i].v, vecs[i].z, vecs[i].color, vecs[i].last, acc);
      check_at(acc + 3, $sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_tri,
               vecs[i].exp_addr, vecs[i].color);
      @(posedge clk); #1;
    end

    // Test 3: same pixel back to back stalls; both writes land; equal depth rejected
    base = wlog.size();
    send_beat(9'd7, 2'd1, 23'd200, 16'h00C8, 1'b0, a1);
    send_beat(9'd7, 2'd1, 23'd50,  16'h0032, 1'b0, a2);
    chk("t3_stall", 32'(a2 - a1), 32'd4);
    check_at(a2 + 3, "t3_second", 1'b1, 1'b0, 11'd327, 16'h0032);
    @(posedge clk); #1;
    chk("t3_writes", 32'(wlog.size() - base), 32'd2);
    if (wlog.size() > base) begin
      chk("t3_first_cyc",  32'(wlog[base].c),    32'(a1 + 3));
      chk("t3_first_data", 32'(wlog[base].data), 32'h00C8);
    end
    send_beat(9'd7, 2'd1, 23'd50, 16'h0099, 1'b0, acc);
    check_at(acc + 3, "t3_equal", 1'b0, 1'b0, 11'd0, 16'h0);
    @(posedge clk); #1;
    chk("t3_writes_total", 32'(wlog.size() - base), 32'd2);

    // Test 4: out-of-range last pixel
    base = wlog.size();
    send_beat(9'd320, 2'd0, 23'd1, 16'h7777, 1'b1, acc);
    check_at(acc + 2, "t4_early", 1'b0, 1'b0, 11'd0, 16'h0);
    check_at(acc + 3, "t4_done",  1'b0, 1'b1, 11'd0, 16'h0);
    @(posedge clk); #1;
    chk("t4_no_write", 32'(wlog.size() - base), 32'd0);

    // Test 5: clear request with 3 beats in flight
    base = wlog.size();
    send_beat(9'd20, 2'd1, 23'd10, 16'h0014, 1'b0, a1);
    send_beat(9'd21, 2'd1, 23'd10, 16'h0015, 1'b0, a2);
    send_beat(9'd22, 2'd1, 23'd10, 16'h0016, 1'b0, a3);
    chk("t5_streamed", 32'(a3 - a1), 32'd2);
    clear = 1'b1;
    #1;
    chk("t5_ready_drop", 32'(ready_out), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t5_drain_ready", 32'(ready_out), 32'd0);
    measure_clear(n, rise);
    chk("t5_retired", 32'(wlog.size() - base), 32'd3);
    if (wlog.size() > 0) chk("t5_order", 32'(wlog[$].c < rise), 32'd1);
    chk("t5_clear_len", 32'(n), 32'(DEPTH));
    @(posedge clk); #1;
    send_beat(9'd5, 2'd2, 23'd1000, 16'h07E0, 1'b0, acc);
    check_at(acc + 3, "t5_after_clear", 1'b1, 1'b0, 11'd645, 16'h07E0);
    @(posedge clk); #1;

    // Test 6: reset discards an in-flight beat; reset mid-clear restarts from 0
    base = wlog.size();
    send_beat(9'd30, 2'd1, 23'd1, 16'h0BEE, 1'b0, acc);
    do_reset(1);
    repeat (1000) begin
      @(posedge clk); #1;
    end
    chk("t6_discarded", 32'(wlog.size() - base), 32'd0);
    chk("t6_mid_clear", 32'(clearing_out), 32'd1);
    do_reset(2);
    measure_clear(n, rise);
    chk("t6_clear_len", 32'(n), 32'(DEPTH));
    chk("t6_ready", 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    send_beat(9'd5, 2'd2, 23'd1000, 16'h001F, 1'b0, acc);
    check_at(acc + 3, "t6_after_reset", 1'b1, 1'b0, 11'd645, 16'h001F);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
